// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy flags and sticky
// overflow/underflow error indicators.
//
// Handshake: there is no ready signal. A write request (we) is taken when the
// FIFO is not full, or when it is full and a read is taken in the same cycle.
// A read request (re) is taken when the FIFO is not empty. A request that
// cannot be taken is dropped, and the matching sticky error flag is set.
// rdata always shows the head entry and is meaningful only while empty is 0.
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clock,
  input  logic                       reset_L,
  input  logic                       clear,
  input  logic                       we,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       re,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   DEPTH_C = AW'(0) + (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come straight from the registered count so they never disagree.
  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
    rdata        = mem[rd_ptr];
    // A full FIFO can still take a write when the head leaves in the same cycle.
    rd_acc       = re && !empty;
    wr_acc       = we && (!full || re);
  end

  // Pointer, occupancy and sticky error state; reset outranks clear.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (we && !wr_acc) overflow  <= 1'b1;
      if (re && empty)   underflow <= 1'b1;
    end
  end

  // Storage array; contents survive reset and clear, only writes change it.
  always_ff @(posedge clock) begin
    if (reset_L && !clear && wr_acc) mem[wr_ptr] <= wdata;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 SHALL derive AW = $clog2(DEPTH) internally; AW is not overridable.
REQ-006 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_L  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port clear  input  1  synchronous flush, active-high.
REQ-009 SHALL have port we  input  1  write request.
REQ-010 SHALL have port wdata  input  WIDTH  write data.
REQ-011 SHALL have port re  input  1  read request (pop head).
REQ-012 SHALL have port rdata  output  WIDTH  current head entry.
REQ-013 SHALL have port full  output  1  count == DEPTH.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-017 SHALL have port count  output  AW+1  number of stored entries (0..DEPTH).
REQ-018 SHALL have port overflow  output  1  sticky: a write was rejected.
REQ-019 SHALL have port underflow  output  1  sticky: a read was rejected.

Function
REQ-020 SHALL store entries in a DEPTH x WIDTH array with AW-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-021 SHALL accept a write iff we && (!full || re); an accepted write stores wdata at wr_ptr and advances wr_ptr.
REQ-022 SHALL accept a read iff re && !empty; an accepted read advances rd_ptr.
REQ-023 SHALL be first-word-fall-through: rdata is the entry at rd_ptr, valid in the same cycle empty is 0, with zero read latency.
REQ-024 SHALL drive rdata as don't-care when empty; the bench must not check it.
REQ-025 SHALL make a written word visible on rdata the cycle after the write when the FIFO was empty (write-to-read latency 1).
REQ-026 SHALL update count +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
REQ-027 SHALL, when full with we && re, accept both; count stays DEPTH and the oldest word is replaced in order.
REQ-028 SHALL, when empty with we && re, accept the write only; underflow sets and count becomes 1.
REQ-029 SHALL set overflow on any cycle with we asserted and the write not accepted; the array and pointers are unchanged.
REQ-030 SHALL set underflow on any cycle with re && empty; pointers are unchanged.
REQ-031 SHALL hold overflow and underflow at 1 until reset_L or clear.
REQ-032 SHALL decode full, empty, almost_full and almost_empty combinationally from the registered count, so all flags are consistent with count in every cycle.
REQ-033 SHALL, on clear=1 (reset_L=1), zero the pointers, count and sticky flags at the next edge, ignoring we and re that cycle; array contents are not cleared.

Reset
REQ-034 SHALL, on reset_L=0 at a rising edge, set wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
REQ-035 SHALL therefore present empty=1, full=0, almost_empty=1, almost_full=0 after reset.
REQ-036 SHALL give reset_L priority over clear, we and re, including reset mid-operation; storage contents are not reset.

Verification
REQ-037 SHALL pass directed test 1: with DEPTH=4, reset, then write 0xA1,0xA2,0xA3,0xA4 -> count 1..4, full=1 after the 4th edge, then 4 reads return A1..A4 in order and empty=1.
REQ-038 SHALL pass directed test 2: with the FIFO full, we=1, re=0, wdata=0xFF -> overflow=1, count=4, the next read returns 0xA1.
REQ-039 SHALL pass directed test 3: with the FIFO empty, re=1 -> underflow=1, count=0; then we && re same cycle -> count=1, underflow stays 1.
REQ-040 SHALL pass directed test 4: with the FIFO full, we && re for 6 cycles with incrementing data -> count stays 4, output order is preserved across pointer wrap.
REQ-041 SHALL pass directed test 5: with DEPTH=16, AF=14, AE=2, fill 0->16 -> almost_empty deasserts at count 3, almost_full asserts at count 14.
REQ-042 SHALL pass directed test 6: with count=3, apply clear with we=1, then separately reset_L=0 with clear=1 -> both give count=0, empty=1, sticky flags 0, and the clear-cycle write is not stored.
